spi_byte_slave: RTL and testbench

//  SPI mode-0 (CPOL=0, CPHA=0), MSB-first slave front end for the control path. It oversamples the

---
 rtl/spi_pkg.sv | 33 +++
 rtl/pin_sync_edge.sv | 46 ++++
 rtl/spi_byte_slave.sv | 154 +++++++++++++++
 tb/tb_spi_byte_slave.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: word width, slave FSM states and the command-byte field layout
// decoded by the downstream command state machine.
package spi_pkg;

    localparam int SPI_WORD_WIDTH = 8;

    typedef enum logic {
        SPI_STATE_IDLE   = 1'b0,
        SPI_STATE_ACTIVE = 1'b1
    } spi_state_e;

    localparam int SPI_CMD_CH_LSB       = 0;
    localparam int SPI_CMD_CH_MSB       = 3;
    localparam int SPI_CMD_SEL_DUTY_BIT = 4;
    localparam int SPI_CMD_WRITE_BIT    = 5;

    typedef struct packed {
        logic [1:0] rsvd;
        logic       write;
        logic       sel_duty;
        logic [3:0] ch;
    } spi_cmd_t;

    function automatic spi_cmd_t spi_decode_cmd(input logic [SPI_WORD_WIDTH-1:0] cmd_byte);
        spi_cmd_t cmd;
        cmd.rsvd     = cmd_byte[7:6];
        cmd.write    = cmd_byte[SPI_CMD_WRITE_BIT];
        cmd.sel_duty = cmd_byte[SPI_CMD_SEL_DUTY_BIT];
        cmd.ch       = cmd_byte[SPI_CMD_CH_MSB:SPI_CMD_CH_LSB];
        return cmd;
    endfunction

endpackage

// File: rtl/pin_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin followed by an edge-detect flop; the level
// and both edge strobes are registered so they line up in the same cycle.
module pin_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              lvl_q, lvl_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    // next-state: shift the pin in, then compare the synchronized level to its last value
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], pin};
        lvl_d  = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~lvl_q;
        fall_d = ~sync_q[STAGES-1] & lvl_q;
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q    = lvl_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/spi_byte_slave.sv
// SPI mode-0 MSB-first byte slave: oversampled pins, receive word strobe and transmit shifter
// fed by the command state machine.
module spi_byte_slave
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WORD_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    output logic             rx_byte_available,
    output logic [WIDTH-1:0] rx_byte,
    output logic             tx_ready_to_write,
    input  logic [WIDTH-1:0] tx_byte,
    output logic             rx_overrun
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise_unused, ss_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic sclk_s_unused;

    pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .pin(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk), .rst(rst), .pin(ss), .q(ss_s), .rise(ss_rise_unused), .fall(ss_fall)
    );

    pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst(rst), .pin(mosi), .q(mosi_s), .rise(mosi_rise_unused),
        .fall(mosi_fall_unused)
    );

    assign sclk_s_unused = sclk_s;

    spi_state_e       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] rx_byte_q, rx_byte_d;
    logic             rx_avail_q, rx_avail_d;
    logic             tx_ready_q, tx_ready_d;
    logic             miso_q, miso_d;
    logic             rx_overrun_q, rx_overrun_d;
    logic [WIDTH-1:0] rx_assembled_s;

    assign rx_assembled_s = {rx_shift_q[WIDTH-2:0], mosi_s};

    // FSM next-state: ss deassertion has priority over any clock edge seen in the same cycle
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        rx_byte_d    = rx_byte_q;
        rx_avail_d   = 1'b0;
        tx_ready_d   = 1'b0;
        miso_d       = miso_q;
        rx_overrun_d = rx_overrun_q;
        case (state_q)
            SPI_STATE_IDLE: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    state_d    = SPI_STATE_ACTIVE;
                    tx_shift_d = tx_byte;
                    bit_cnt_d  = '0;
                    miso_d     = tx_byte[WIDTH-1];
                end else begin
                    state_d = SPI_STATE_IDLE;
                end
            end
            SPI_STATE_ACTIVE: begin
                if (ss_s) begin
                    // a partial word is dropped and flagged; a boundary exit is a clean end
                    state_d   = SPI_STATE_IDLE;
                    miso_d    = 1'b0;
                    bit_cnt_d = '0;
                    if (bit_cnt_q != '0) begin
                        rx_overrun_d = 1'b1;
                    end else begin
                        rx_overrun_d = rx_overrun_q;
                    end
                end else if (sclk_rise) begin
                    rx_shift_d = rx_assembled_s;
                    if (bit_cnt_q == CNT_LAST) begin
                        rx_byte_d  = rx_assembled_s;
                        rx_avail_d = 1'b1;
                        tx_ready_d = 1'b1;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    // the fall after a completed word loads the next tx word
                    if (bit_cnt_q == '0) begin
                        tx_shift_d = tx_byte;
                        miso_d     = tx_byte[WIDTH-1];
                    end else begin
                        tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
                        miso_d     = tx_shift_q[WIDTH-2];
                    end
                end else begin
                    state_d = SPI_STATE_ACTIVE;
                end
            end
            default: begin
                state_d   = SPI_STATE_IDLE;
                miso_d    = 1'b0;
                bit_cnt_d = '0;
            end
        endcase
    end

    // FSM and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SPI_STATE_IDLE;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            rx_byte_q    <= '0;
            rx_avail_q   <= 1'b0;
            tx_ready_q   <= 1'b0;
            miso_q       <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            rx_byte_q    <= rx_byte_d;
            rx_avail_q   <= rx_avail_d;
            tx_ready_q   <= tx_ready_d;
            miso_q       <= miso_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign miso              = miso_q;
    assign rx_byte_available = rx_avail_q;
    assign rx_byte           = rx_byte_q;
    assign tx_ready_to_write = tx_ready_q;
    assign rx_overrun        = rx_overrun_q;

endmodule

// File: tb/tb_spi_byte_slave.sv
// Self-checking bench for spi_byte_slave: bit-banged mode-0 master, rx scoreboard queue and
// a tx feeder that answers each tx_ready_to_write strobe.
module tb_spi_byte_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       ss;
    logic       mosi;
    logic       miso;
    logic       rx_byte_available;
    logic [7:0] rx_byte;
    logic       tx_ready_to_write;
    logic [7:0] tx_byte;
    logic       rx_overrun;

    spi_byte_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
        .rx_byte_available(rx_byte_available), .rx_byte(rx_byte),
        .tx_ready_to_write(tx_ready_to_write), .tx_byte(tx_byte), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] mosi_word;
        logic [7:0] tx_word;
        int         half;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_txr = 0;
    int         n_txr_exp = 0;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] bmo[16];
    logic [7:0] btx[16];
    logic [7:0] last_rx = 8'h00;
    vec_t       vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sampled on the falling clk edge, well away from the active edge.
    task automatic monitor();
        if (rx_byte_available) begin
            if (rxq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rx_strobe: got unexpected strobe with rx_byte %0h at %0t",
                         rx_byte, $time);
            end else begin
                check("rx_byte", {24'h0, rx_byte}, {24'h0, rxq.pop_front()});
            end
        end
        if (tx_ready_to_write) begin
            n_txr++;
            if (txq.size() != 0) tx_byte = txq.pop_front();
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            monitor();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [7:0] mo, input logic [7:0] txe, input int nb,
                             input int half, input bit chk_miso);
        for (int i = 0; i < nb; i++) begin
            mosi = mo[7-i];
            tick(half);
            if (chk_miso) check("miso_bit", {31'h0, miso}, {31'h0, txe[7-i]});
            sclk = 1'b1;
            tick(half);
            sclk = 1'b0;
        end
    endtask

    task automatic burst(input int n, input int half);
        txq.delete();
        tx_byte = btx[0];
        for (int i = 1; i < n; i++) txq.push_back(btx[i]);
        tick(2);
        ss = 1'b0;
        for (int w = 0; w < n; w++) begin
            rxq.push_back(bmo[w]);
            last_rx = bmo[w];
            n_txr_exp++;
            send_bits(bmo[w], btx[w], 8, half, 1'b1);
        end
        tick(half);
        ss = 1'b1;
        tick(2 * half + 6);
        check("miso_idle", {31'h0, miso}, 32'h0);
    endtask

    initial begin
        vecs[0] = '{8'h3C, 8'hA5, 8};
        vecs[1] = '{8'hFF, 8'h00, 4};
        vecs[2] = '{8'h00, 8'hFF, 6};
        vecs[3] = '{8'h81, 8'h7E, 16};
        vecs[4] = '{8'h55, 8'hAA, 4};

        rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; tx_byte = 8'h00;
        @(posedge clk);
        #1;
        tick(4);
        rst = 1'b0;
        tick(4);
        check("rst_miso", {31'h0, miso}, 32'h0);
        check("rst_rx_avail", {31'h0, rx_byte_available}, 32'h0);
        check("rst_rx_byte", {24'h0, rx_byte}, 32'h0);
        check("rst_tx_ready", {31'h0, tx_ready_to_write}, 32'h0);
        check("rst_overrun", {31'h0, rx_overrun}, 32'h0);

        // single-word transfers, first entry at clk/SCLK = 16
        for (int v = 0; v < 5; v++) begin
            bmo[0] = vecs[v].mosi_word;
            btx[0] = vecs[v].tx_word;
            burst(1, vecs[v].half);
            check("rx_byte_held", {24'h0, rx_byte}, {24'h0, vecs[v].mosi_word});
        end

        // three-word burst with tx words supplied on tx_ready_to_write
        bmo[0] = 8'h21; bmo[1] = 8'hE2; bmo[2] = 8'h04;
        btx[0] = 8'h6B; btx[1] = 8'hE2; btx[2] = 8'h04;
        burst(3, 8);
        check("burst_overrun", {31'h0, rx_overrun}, 32'h0);

        // ss deasserted after 5 bits
        tx_byte = 8'hC3;
        tick(2);
        ss = 1'b0;
        send_bits(8'hF0, 8'hC3, 5, 8, 1'b1);
        tick(8);
        ss = 1'b1;
        tick(20);
        check("partial_overrun", {31'h0, rx_overrun}, 32'h1);
        check("partial_rx_kept", {24'h0, rx_byte}, {24'h0, last_rx});
        bmo[0] = 8'h99; btx[0] = 8'h66;
        burst(1, 8);
        check("overrun_sticky", {31'h0, rx_overrun}, 32'h1);

        // reset in the middle of a word while ss stays low
        tx_byte = 8'h3E;
        tick(2);
        ss = 1'b0;
        send_bits(8'hA7, 8'h3E, 3, 8, 1'b1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        check("midrst_overrun", {31'h0, rx_overrun}, 32'h0);
        check("midrst_rx_byte", {24'h0, rx_byte}, 32'h0);
        send_bits(8'h38, 8'h00, 5, 8, 1'b1);
        send_bits(8'hC4, 8'h00, 8, 8, 1'b1);
        tick(8);
        ss = 1'b1;
        tick(20);
        check("midrst_overrun_after", {31'h0, rx_overrun}, 32'h0);
        check("midrst_rx_after", {24'h0, rx_byte}, 32'h0);
        bmo[0] = 8'h5A; btx[0] = 8'h96;
        burst(1, 8);

        // ratio sweep with random 16-word bursts
        for (int r = 8; r <= 32; r += 4) begin
            for (int i = 0; i < 16; i++) begin
                bmo[i] = 8'($urandom_range(0, 255));
                btx[i] = 8'($urandom_range(0, 255));
            end
            burst(16, r / 2);
        end

        tick(10);
        check("rx_pending", rxq.size(), 32'h0);
        check("tx_ready_count", n_txr, n_txr_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
